// File: rtl/adj_row_argmax.sv
// Per-node argmax over the aggregated FM*WM*ADJ rows; scans one row per cycle once aggregation is done.
// Optional macro ARGMAX_SIGNED_EN selects two's-complement comparison (unsigned when undefined).
module adj_row_argmax #(
   parameter int FEATURE_ROWS          = 6,
   parameter int WEIGHT_COLS           = 3,
   parameter int DOT_PROD_WIDTH        = 16,
   parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
   parameter int MAX_ADDRESS_WIDTH     = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             ADJ_fm_wm_done,
   input  logic [DOT_PROD_WIDTH-1:0]        fm_wm_adj_row_mem_out [0:WEIGHT_COLS-1],
   output logic [COUNTER_FEATURE_WIDTH-1:0] read_MAX_adj_row,
   output logic [MAX_ADDRESS_WIDTH-1:0]     max_addi_answer [0:FEATURE_ROWS-1],
   output logic                             done
);

   // state  | meaning
   // IDLE   | waiting for ADJ_fm_wm_done; answers from the last full pass are kept
   // SCAN   | one row per cycle, argmax written to max_addi_answer[row]
   // FINISH | all answers valid, done high until ADJ_fm_wm_done drops
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);

   state_t                           state, state_nxt;
   logic [COUNTER_FEATURE_WIDTH-1:0] row_cnt, row_nxt;
   logic                             ans_wr;
   logic                             ans_clr;
   logic [DOT_PROD_WIDTH-1:0]        best_val;
   logic [MAX_ADDRESS_WIDTH-1:0]     best_idx;

   function automatic logic is_greater(input logic [DOT_PROD_WIDTH-1:0] a,
                                       input logic [DOT_PROD_WIDTH-1:0] b);
`ifdef ARGMAX_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   // Strictly-greater replacement keeps the lowest index on ties.
   always_comb begin
      best_val = fm_wm_adj_row_mem_out[0];
      best_idx = '0;
      for (int c = 1; c < WEIGHT_COLS; c++) begin
         if (is_greater(fm_wm_adj_row_mem_out[c], best_val)) begin
            best_val = fm_wm_adj_row_mem_out[c];
            best_idx = MAX_ADDRESS_WIDTH'(c);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         row_cnt <= '0;
      end else begin
         state   <= state_nxt;
         row_cnt <= row_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      row_nxt   = row_cnt;
      ans_wr    = 1'b0;
      ans_clr   = 1'b0;
      case (state)
         IDLE: begin
            row_nxt = '0;
            if (ADJ_fm_wm_done) state_nxt = SCAN;
         end
         SCAN: begin
            if (!ADJ_fm_wm_done) begin
               // Aborted pass: a partial answer set must never be visible.
               state_nxt = IDLE;
               row_nxt   = '0;
               ans_clr   = 1'b1;
            end else begin
               ans_wr = 1'b1;
               if (row_cnt == LAST_ROW) begin
                  state_nxt = FINISH;
                  row_nxt   = '0;
               end else begin
                  row_nxt = row_cnt + 1'b1;
               end
            end
         end
         FINISH: begin
            if (!ADJ_fm_wm_done) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            row_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < FEATURE_ROWS; r++) max_addi_answer[r] <= '0;
      end else begin
         for (int r = 0; r < FEATURE_ROWS; r++) begin
            if (ans_clr) begin
               max_addi_answer[r] <= '0;
            end else if (ans_wr && (row_cnt == COUNTER_FEATURE_WIDTH'(r))) begin
               max_addi_answer[r] <= best_idx;
            end
         end
      end
   end

   assign read_MAX_adj_row = (state == SCAN) ? row_cnt : '0;
   assign done             = (state == FINISH);

endmodule

// File: tb/tb_adj_row_argmax.sv
// Directed bench for adj_row_argmax: reset, full passes, ties, signedness, abort, hold/restart, async reset.
module tb_adj_row_argmax;

   localparam int ROWS = 6;
   localparam int COLS = 3;

   logic        clk;
   logic        reset;
   logic        adj_done;
   logic [15:0] row_data [0:COLS-1];
   logic [2:0]  read_row;
   logic [1:0]  answer [0:ROWS-1];
   logic        done;

   logic [15:0] mem [0:ROWS-1][0:COLS-1];
   int          exp_ans [0:ROWS-1];
   int          total;
   int          bad;

   adj_row_argmax dut (
      .clk                   (clk),
      .reset                 (reset),
      .ADJ_fm_wm_done        (adj_done),
      .fm_wm_adj_row_mem_out (row_data),
      .read_MAX_adj_row      (read_row),
      .max_addi_answer       (answer),
      .done                  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         row_data[c] = (read_row < 3'(ROWS)) ? mem[read_row][c] : 16'h0000;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic set_row(input int r, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      mem[r][0] = a;
      mem[r][1] = b;
      mem[r][2] = c;
   endtask

   task automatic set_exp(input int a0, input int a1, input int a2, input int a3, input int a4, input int a5);
      exp_ans[0] = a0; exp_ans[1] = a1; exp_ans[2] = a2;
      exp_ans[3] = a3; exp_ans[4] = a4; exp_ans[5] = a5;
   endtask

   task automatic check_answers(input string tag);
      for (int r = 0; r < ROWS; r++) check($sformatf("%s_ans%0d", tag, r), int'(answer[r]), exp_ans[r]);
   endtask

   task automatic load_basic();
      set_row(0, 16'd1, 16'd9, 16'd3);
      set_row(1, 16'd7, 16'd2, 16'd2);
      set_row(2, 16'd0, 16'd0, 16'd5);
      set_row(3, 16'd4, 16'd8, 16'd1);
      set_row(4, 16'd6, 16'd6, 16'd6);
      set_row(5, 16'd2, 16'd1, 16'd0);
      set_exp(1, 0, 2, 1, 0, 0);
   endtask

   // Called at a negedge with adj_done low; raises it so the next posedge is E0.
   task automatic run_pass(input string tag);
      adj_done = 1'b1;
      for (int k = 0; k < ROWS; k++) begin
         @(negedge clk);
         check($sformatf("%s_addr%0d", tag, k), int'(read_row), k);
         check($sformatf("%s_nodone%0d", tag, k), int'(done), 0);
      end
      @(negedge clk);
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_addr_fin"}, int'(read_row), 0);
      check_answers(tag);
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      reset    = 1'b0;
      adj_done = 1'b0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) mem[r][c] = 16'($urandom);
      set_exp(0, 0, 0, 0, 0, 0);

      // Reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         adj_done = 1'($urandom);
         @(negedge clk);
         check("rst_done", int'(done), 0);
         check("rst_addr", int'(read_row), 0);
         check_answers("rst");
      end
      adj_done = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Basic pass
      load_basic();
      run_pass("basic");

      // Hold high after done: no rescan, answers stable
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_done", int'(done), 1);
         check("hold_addr", int'(read_row), 0);
      end
      check_answers("hold");

      // Drop: done clears, answers retained
      adj_done = 1'b0;
      @(negedge clk);
      check("drop_done", int'(done), 0);
      check_answers("drop");

      // New data: signedness and ties
      set_row(0, 16'hFFFF, 16'h0001, 16'h0000);
      set_row(1, 16'd5, 16'd5, 16'd5);
      set_row(2, 16'd3, 16'd7, 16'd7);
      set_row(3, 16'd0, 16'd0, 16'd0);
      set_row(4, 16'd2, 16'd3, 16'd3);
      set_row(5, 16'h8000, 16'h7FFF, 16'h0000);
`ifdef ARGMAX_SIGNED_EN
      set_exp(1, 0, 1, 0, 1, 1);
`else
      set_exp(0, 0, 1, 0, 1, 0);
`endif
      run_pass("sign_tie");

      // Abort after three rows written
      adj_done = 1'b0;
      @(negedge clk);
      load_basic();
      adj_done = 1'b1;
      for (int k = 0; k < 4; k++) @(negedge clk);
      check("abort_addr3", int'(read_row), 3);
      check("abort_part0", int'(answer[0]), 1);
      check("abort_part2", int'(answer[2]), 2);
      adj_done = 1'b0;
      set_exp(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_done", int'(done), 0);
         check("abort_addr", int'(read_row), 0);
      end
      check_answers("abort");

      // Re-raise after abort
      load_basic();
      run_pass("rerun");

      // Async reset mid-scan
      adj_done = 1'b0;
      @(negedge clk);
      adj_done = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      set_exp(0, 0, 0, 0, 0, 0);
      check("arst_done", int'(done), 0);
      check("arst_addr", int'(read_row), 0);
      check_answers("arst");
      @(negedge clk);
      adj_done = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
